// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises an async reset request, merges a software reset, then
// releases CHANNELS active-high resets in order with a programmable gap and optional acks.
module rst_seq_ctrl #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned HOLD        = 4,
  parameter int unsigned REL_DELAY   = 3,
  parameter int unsigned WAIT_ACK    = 0,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                req_rst_i,
  input  logic                sw_rst_i,
  input  logic [CHANNELS-1:0] ack_i,
  output logic [CHANNELS-1:0] rst_o,
  output logic                ready_o,
  output logic                err_o
);

  localparam int unsigned CntMax0 = (HOLD > ACK_TIMEOUT) ? HOLD : ACK_TIMEOUT;
  localparam int unsigned CntMax  = (CntMax0 > REL_DELAY) ? CntMax0 : REL_DELAY;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned StepW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD - 1);
  localparam logic [CntW-1:0]  RelLast  = CntW'(REL_DELAY - 1);
  localparam logic [CntW-1:0]  ToLast   = CntW'(ACK_TIMEOUT - 1);
  localparam logic [StepW-1:0] LastStep = StepW'(CHANNELS - 1);

  localparam logic [1:0] StAssert = 2'd0;
  localparam logic [1:0] StStep   = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [STAGES-1:0]   sync_q;
  logic [1:0]          state_q, state_d;
  logic [StepW-1:0]    step_q, step_d, step_nxt;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0] rst_q, rst_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                req, ack_hit, advance, timeout;

  assign req      = sync_q[STAGES-1] | sw_rst_i;
  assign step_nxt = step_q + 1'b1;
  assign ack_hit  = (WAIT_ACK != 0) && (cnt_q >= RelLast) && ack_i[step_q];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q + 1'b1;
    rst_d   = rst_q;
    ready_d = ready_q;
    err_d   = err_q;
    advance = 1'b0;
    timeout = 1'b0;
    if (req) begin
      state_d = StAssert;
      step_d  = '0;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            state_d  = StStep;
            step_d   = '0;
            cnt_d    = '0;
            rst_d[0] = 1'b0;
          end
        end
        StStep: begin
          if (WAIT_ACK == 0) begin
            advance = (cnt_q == RelLast);
          end else begin
            // An ack arriving on the timeout edge counts as a clean ack.
            timeout = !ack_hit && (cnt_q == ToLast);
            advance = ack_hit || timeout;
          end
          if (advance) begin
            cnt_d = '0;
            if (timeout) err_d = 1'b1;
            if (step_q == LastStep) begin
              state_d = StDone;
              ready_d = 1'b1;
            end else begin
              step_d          = step_nxt;
              rst_d[step_nxt] = 1'b0;
            end
          end
        end
        StDone: cnt_d = cnt_q;
        default: begin
          state_d = StAssert;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= StAssert;
      step_q  <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], req_rst_i};
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign rst_o   = rst_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: one default instance (a) and one WAIT_ACK=1, ACK_TIMEOUT=8
// instance (b); every applied vector queues its expected outputs for the post-edge check.
module tb_rst_seq_ctrl;

  localparam int HOLD = 4;
  localparam int REL  = 3;

  typedef struct {
    logic       rst;
    logic       req;
    logic       sw;
    logic [3:0] ack;
    logic       sel;
    logic [3:0] e_rst;
    logic       e_rdy;
    logic       e_err;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1, req_rst_i = 1'b0, sw_rst_i = 1'b0;
  logic [3:0] ack_a = 4'hF, ack_b = 4'h0;
  logic [3:0] rst_a, rst_b;
  logic       rdy_a, rdy_b, err_a, err_b;

  int   checks = 0;
  int   errors = 0;
  vec_t sb_q[$];
  vec_t tbl[21];

  always #5 clk = ~clk;

  rst_seq_ctrl dut_a (
    .clk       (clk),
    .rst_i     (rst_i),
    .req_rst_i (req_rst_i),
    .sw_rst_i  (sw_rst_i),
    .ack_i     (ack_a),
    .rst_o     (rst_a),
    .ready_o   (rdy_a),
    .err_o     (err_a)
  );

  rst_seq_ctrl #(
    .WAIT_ACK    (1),
    .ACK_TIMEOUT (8)
  ) dut_b (
    .clk       (clk),
    .rst_i     (rst_i),
    .req_rst_i (req_rst_i),
    .sw_rst_i  (sw_rst_i),
    .ack_i     (ack_b),
    .rst_o     (rst_b),
    .ready_o   (rdy_b),
    .err_o     (err_b)
  );

  function automatic vec_t mk(logic rst, logic req, logic sw, logic [3:0] ack, logic sel,
                              logic [3:0] e_rst, logic e_rdy, logic e_err, string name);
    vec_t v;
    v.rst = rst; v.req = req; v.sw = sw; v.ack = ack; v.sel = sel;
    v.e_rst = e_rst; v.e_rdy = e_rdy; v.e_err = e_err; v.name = name;
    return v;
  endfunction

  // Expected channel resets n edges into a WAIT_ACK=0 sequence.
  function automatic logic [3:0] sched_rst(int n);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (n < HOLD + k * REL);
    return r;
  endfunction

  function automatic logic sched_rdy(int n);
    return n >= HOLD + 4 * REL;
  endfunction

  task automatic check_pop();
    vec_t       e;
    logic [5:0] act, exp;
    e   = sb_q.pop_front();
    act = e.sel ? {rst_b, rdy_b, err_b} : {rst_a, rdy_a, err_a};
    exp = {e.e_rst, e.e_rdy, e.e_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut_%s) @%0t: rst_o/ready_o/err_o got %b_%b_%b expected %b_%b_%b",
               e.name, e.sel ? "b" : "a", $time, act[5:2], act[1], act[0],
               exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(vec_t v);
    rst_i     = v.rst;
    req_rst_i = v.req;
    sw_rst_i  = v.sw;
    ack_b     = v.ack;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic run_sched(int lo, int hi, string name);
    for (int n = lo; n <= hi; n++)
      apply(mk(0, 0, 0, 4'h0, 0, sched_rst(n), sched_rdy(n), 0, name));
  endtask

  task automatic b_run(int cnt, logic [3:0] ack, logic [3:0] e_rst, logic e_rdy, logic e_err,
                       string name);
    for (int i = 0; i < cnt; i++) apply(mk(0, 0, 0, ack, 1, e_rst, e_rdy, e_err, name));
  endtask

  initial begin
    // Power-up table: three reset cycles then the full WAIT_ACK=0 release schedule.
    for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 0, 4'h0, 0, 4'hF, 0, 0, "pwr_reset");
    for (int n = 1; n <= 18; n++)
      tbl[2 + n] = mk(0, 0, 0, 4'h0, 0, sched_rst(n), sched_rdy(n), 0, "pwr_sched");
    for (int i = 0; i < 21; i++) apply(tbl[i]);

    // 2-cycle req_rst_i pulse in DONE: re-assert after 3 edges, schedule restarts.
    apply(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 0, "req_pulse_sync"));
    apply(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 0, "req_pulse_sync"));
    apply(mk(0, 0, 0, 4'h0, 0, 4'hF, 0, 0, "req_pulse_assert"));
    apply(mk(0, 0, 0, 4'h0, 0, 4'hF, 0, 0, "req_pulse_assert"));
    run_sched(1, 17, "req_pulse_sched");

    // sw_rst_i one edge after rst_o[1] release.
    apply(mk(1, 0, 0, 4'h0, 0, 4'hF, 0, 0, "sw_prep_reset"));
    run_sched(1, 7, "sw_prep_sched");
    apply(mk(0, 0, 1, 4'h0, 0, 4'hF, 0, 0, "sw_pulse_assert"));
    run_sched(1, 17, "sw_sched");

    // req_rst_i held for 20 cycles.
    for (int i = 1; i <= 20; i++)
      apply(mk(0, 1, 0, 4'h0, 0, (i <= 2) ? 4'h0 : 4'hF, i <= 2, 0, "req_held"));
    apply(mk(0, 0, 0, 4'h0, 0, 4'hF, 0, 0, "req_held_tail"));
    apply(mk(0, 0, 0, 4'h0, 0, 4'hF, 0, 0, "req_held_tail"));
    run_sched(1, 6, "req_held_sched");

    // WAIT_ACK=1, ACK_TIMEOUT=8 on dut_b. Acks of other channels are ignored.
    apply(mk(1, 0, 0, 4'h0, 1, 4'hF, 0, 0, "ack_reset"));
    b_run(3, 4'h0, 4'hF, 0, 0, "ack_hold");
    b_run(1, 4'h0, 4'hE, 0, 0, "ack_rel0");
    b_run(4, 4'hC, 4'hE, 0, 0, "ack_wait0");
    b_run(1, 4'hD, 4'hC, 0, 0, "ack_hit0");
    b_run(7, 4'hC, 4'hC, 0, 0, "ack_wait1");
    b_run(1, 4'hC, 4'h8, 0, 1, "ack_timeout1");
    b_run(2, 4'hC, 4'h8, 0, 1, "ack_min_delay2");
    b_run(1, 4'hC, 4'h0, 0, 1, "ack_hit2");
    b_run(2, 4'hC, 4'h0, 0, 1, "ack_min_delay3");
    b_run(1, 4'hC, 4'h0, 1, 1, "ack_done");
    b_run(2, 4'hC, 4'h0, 1, 1, "ack_err_sticky");
    apply(mk(0, 0, 1, 4'h0, 1, 4'hF, 0, 0, "ack_sw_clear"));

    // Ack on the timeout edge wins; then rst_i in STEP(2) with err_o set.
    b_run(3, 4'h0, 4'hF, 0, 0, "tie_hold");
    b_run(1, 4'h0, 4'hE, 0, 0, "tie_rel0");
    b_run(7, 4'h0, 4'hE, 0, 0, "tie_wait0");
    b_run(1, 4'h1, 4'hC, 0, 0, "tie_ack_at_timeout");
    b_run(7, 4'h0, 4'hC, 0, 0, "tie_wait1");
    b_run(1, 4'h0, 4'h8, 0, 1, "tie_timeout1");
    apply(mk(1, 0, 0, 4'h0, 1, 4'hF, 0, 0, "step2_rst_i"));
    b_run(3, 4'h0, 4'hF, 0, 0, "restart_hold");
    b_run(2, 4'h0, 4'hE, 0, 0, "restart_rel0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
